// File: rtl/display_pkg.sv
// Shared constants for the five-digit multiplexed 7-segment display.
// Segment patterns are active-low and ordered gfedcba.
package display_pkg;

    localparam int NUM_DIGITS = 5;

    typedef logic [3:0] bcd_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [NUM_DIGITS-1:0] AN_OFF = '1;

    function automatic logic [NUM_DIGITS-1:0] an_onecold(
        input logic [2:0] idx
    );
        return ~(NUM_DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/bcd_display_scan_if.sv
// Signal bundle between a BCD source/observer and the display scanner.
// master drives digits and controls; slave drives the display lines.
interface bcd_display_scan_if;
    import display_pkg::*;

    logic                  enable;
    logic                  load;
    bcd_t                  D5;
    bcd_t                  D4;
    bcd_t                  D3;
    bcd_t                  D2;
    bcd_t                  D1;
    logic [NUM_DIGITS-1:0] an;
    logic [6:0]            seg;
    logic                  frame_done;

    modport master (
        output enable, load, D5, D4, D3, D2, D1,
        input  an, seg, frame_done
    );

    modport slave (
        input  enable, load, D5, D4, D3, D2, D1,
        output an, seg, frame_done
    );

endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low 7-segment decode (gfedcba).
// Codes 10..15 render as a dash.
module seg7_decode
    import display_pkg::*;
(
    input  bcd_t       bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scan.sv
// Five-digit multiplexed 7-segment scanner with shadow digit registers.
// Define LEADING_ZERO_BLANK_EN to blank zeros above the leading digit.
module bcd_display_scan
    import display_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  load,
    input  bcd_t                  D5,
    input  bcd_t                  D4,
    input  bcd_t                  D3,
    input  bcd_t                  D2,
    input  bcd_t                  D1,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  frame_done
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [2:0] IDX_LAST = 3'(NUM_DIGITS - 1);

    logic [PW-1:0]         presc_q, presc_d;
    logic [2:0]            idx_q, idx_d;
    bcd_t                  shadow_q [NUM_DIGITS];
    bcd_t                  shadow_d [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [6:0]            seg_q, seg_d;
    logic                  fd_q, fd_d;
    logic                  tick;
    logic [6:0]            dec;
    logic [NUM_DIGITS-1:0] blank;

    seg7_decode u_dec (
        .bcd_i (shadow_q[idx_q]),
        .seg_o (dec)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic zeros;

    // A slot is blank while it and every slot above it hold zero.
    always_comb begin
        blank = '0;
        zeros = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            zeros    = zeros & (shadow_q[k] == 4'd0);
            blank[k] = zeros;
        end
    end
`else
    assign blank = '0;
`endif

    always_comb begin
        tick    = (presc_q == PRESC_MAX);
        presc_d = tick ? '0 : presc_q + 1'b1;

        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
        end

        shadow_d = shadow_q;
        if (load) begin
            shadow_d[0] = D1;
            shadow_d[1] = D2;
            shadow_d[2] = D3;
            shadow_d[3] = D4;
            shadow_d[4] = D5;
        end

        fd_d = tick && (idx_q == IDX_LAST);

        an_d  = AN_OFF;
        seg_d = SEG_BLANK;
        if (enable && !blank[idx_q]) begin
            an_d  = an_onecold(idx_q);
            seg_d = dec;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q  <= '0;
            idx_q    <= '0;
            shadow_q <= '{default: '0};
            an_q     <= AN_OFF;
            seg_q    <= SEG_BLANK;
            fd_q     <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            fd_q     <= fd_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench for bcd_display_scan with SCAN_DIV=4.
// Expected display state is predicted per edge and checked after it.
module tb_bcd_display_scan;
    import display_pkg::*;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    typedef struct {
        logic [4:0] an;
        logic [6:0] seg;
        logic       fd;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bcd_display_scan_if bus ();

    bcd_display_scan #(.SCAN_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (bus.enable),
        .load       (bus.load),
        .D5         (bus.D5),
        .D4         (bus.D4),
        .D3         (bus.D3),
        .D2         (bus.D2),
        .D1         (bus.D1),
        .an         (bus.an),
        .seg        (bus.seg),
        .frame_done (bus.frame_done)
    );

    logic [6:0] seg_ref [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
        7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
    };

    exp_t       sb [$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         fd_cnt  = 0;
    int         m_t     = 0;
    logic [3:0] m_sh [5];
    logic [3:0] din [5];
    string      phase = "init";

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s/%s: got %h expected %h t=%0t",
                     phase, tag, got, exp, $time);
        end
    endtask

    task automatic set_d(input logic [3:0] d5, input logic [3:0] d4,
                         input logic [3:0] d3, input logic [3:0] d2,
                         input logic [3:0] d1);
        din[4] = d5;
        din[3] = d4;
        din[2] = d3;
        din[1] = d2;
        din[0] = d1;
    endtask

    // Time-based view: m_t counts unreset edges, digit = (m_t/4)%5.
    task automatic predict();
        exp_t e;
        int   idx;
        int   msd;
        e.an  = 5'b11111;
        e.seg = 7'b1111111;
        e.fd  = 1'b0;
        if (rst) begin
            m_t = 0;
            for (int k = 0; k < 5; k++) m_sh[k] = 4'd0;
        end else begin
            idx = (m_t / 4) % 5;
            msd = 0;
            for (int k = 0; k < 5; k++) begin
                if (m_sh[k] != 4'd0) msd = k;
            end
            if (bus.enable && (!LZB || idx <= msd)) begin
                e.an  = 5'b11111 ^ (5'b00001 << idx);
                e.seg = seg_ref[m_sh[idx]];
            end
            e.fd = ((m_t % 20) == 19);
            m_t++;
            if (bus.load) begin
                for (int k = 0; k < 5; k++) m_sh[k] = din[k];
            end
        end
        sb.push_back(e);
    endtask

    task automatic cyc();
        exp_t e;
        bus.D1 = din[0];
        bus.D2 = din[1];
        bus.D3 = din[2];
        bus.D4 = din[3];
        bus.D5 = din[4];
        predict();
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("an", 32'(bus.an), 32'(e.an));
        check("seg", 32'(bus.seg), 32'(e.seg));
        check("frame_done", 32'(bus.frame_done), 32'(e.fd));
        if (bus.frame_done === 1'b1) fd_cnt++;
    endtask

    task automatic load_pulse();
        bus.load = 1'b1;
        cyc();
        bus.load = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        bus.enable = 1'b0;
        bus.load   = 1'b0;
        set_d(0, 0, 0, 0, 0);

        phase = "reset";
        repeat (2) cyc();

        rst        = 1'b0;
        phase      = "scan65535";
        bus.enable = 1'b1;
        set_d(6, 5, 5, 3, 5);
        fd_cnt = 0;
        load_pulse();
        repeat (40) cyc();
        check("fd_count", 32'(fd_cnt), 32'd2);

        phase = "lead_zero";
        set_d(0, 0, 0, 4, 2);
        load_pulse();
        repeat (20) cyc();

        phase = "all_zero";
        set_d(0, 0, 0, 0, 0);
        load_pulse();
        repeat (20) cyc();

        phase = "dash";
        set_d(1, 2, 4'hA, 4, 5);
        load_pulse();
        repeat (20) cyc();

        phase = "enable";
        repeat (3) cyc();
        bus.enable = 1'b0;
        repeat (6) cyc();
        bus.enable = 1'b1;
        repeat (10) cyc();

        phase = "load_tick";
        while ((m_t % 4) != 3) cyc();
        set_d(9, 8, 7, 6, 4'hF);
        load_pulse();
        repeat (8) cyc();

        phase = "rst_mid";
        repeat (7) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        repeat (24) cyc();

        phase = "random";
        repeat (60) begin
            set_d(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 9)),
                  4'($urandom_range(0, 9)));
            bus.load   = ($urandom_range(0, 3) == 0);
            bus.enable = ($urandom_range(0, 7) != 0);
            cyc();
        end
        bus.load = 1'b0;

        phase = "end";
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bcd_display_scan.md
BCD_DISPLAY_SCAN -- requirements
Module: bcd_display_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clock cycles each digit is held; legal values 2..2^20.
REQ-002 SHALL have port clk, input, 1: single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port enable, input, 1: display enable; 0 blanks the display.
REQ-005 SHALL have port load, input, 1: strobe that latches D5..D1 into shadow registers.
REQ-006 SHALL have ports D5, D4, D3, D2, D1, input, 4 each: BCD digits from the binary-to-BCD stage; D5 is the most significant.
REQ-007 SHALL have port an, output, 5: active-low digit select; an[0] selects D1 and an[4] selects D5.
REQ-008 SHALL have port seg, output, 7: active-low segments, ordered gfedcba (seg[6]=g).
REQ-009 SHALL have port frame_done, output, 1: one-cycle pulse when a full 5-digit scan completes.

Function
REQ-010 SHALL latch D5..D1 into the shadow registers on any clock edge where load=1; the display SHALL use only shadow values.
REQ-011 SHALL run the prescaler 0..SCAN_DIV-1 and wrap to 0; a tick SHALL occur on the cycle the prescaler equals SCAN_DIV-1.
REQ-012 SHALL advance the digit index 0->1->2->3->4->0 on each tick; index 0 is D1.
REQ-013 SHALL pulse frame_done for exactly one cycle on the tick where the index wraps from 4 to 0.
REQ-014 SHALL register an and seg, so they reflect the index and shadow values one cycle after those change.
REQ-015 SHALL drive an as the one-cold pattern of the current index when enable=1.
REQ-016 SHALL encode digits 0-9 to standard 7-segment patterns (0=1000000, 1=1111001, 8=0000000).
REQ-017 SHALL display any shadow digit value 10..15 as a dash (seg=0111111).
REQ-018 SHALL force an=11111 and seg=1111111 on the next edge when enable=0, while the prescaler, index and frame_done keep running.
REQ-019 SHALL, when load and a tick occur in the same cycle, show the newly latched value for the new index on the following cycle.
REQ-020 SHALL not restart the scan or alter its phase on load.

Reset
REQ-021 SHALL, on any clock edge with rst=1, set the shadow digits to 0, the prescaler to 0, the index to 0, an=11111, seg=1111111 and frame_done=0.
REQ-022 SHALL give rst priority over load, enable and tick.
REQ-023 SHALL, when rst is asserted mid-scan, resume from index 0 with a full SCAN_DIV period after rst is released.

Configuration
REQ-024 SHALL, with macro LEADING_ZERO_BLANK_EN defined, blank every digit above the most significant nonzero shadow digit (an bit high for that slot); D1 is never blanked.
REQ-025 SHALL, without LEADING_ZERO_BLANK_EN defined, display all five digits including leading zeros.
REQ-026 SHALL treat shadow digits 10..15 as nonzero for the blanking decision.

Structure
REQ-027 SHALL place the segment constants (digit patterns, dash, blank) and the digit-count constant (5) in shared package display_pkg.
REQ-028 SHALL implement the BCD-to-segment decode as sub-module seg7_decode (4-bit in, 7-bit active-low out, combinational).
REQ-029 SHALL size the prescaler as ceil(log2(SCAN_DIV)) bits.

Verification (bench uses SCAN_DIV=4)
REQ-030 SHALL cover: rst=1 for 2 cycles -> an=11111, seg=1111111, frame_done=0.
REQ-031 SHALL cover: load with D5..D1=6,5,5,3,5 (65535), enable=1 -> an steps 11110,11101,11011,10111,01111 every 4 cycles; seg shows 5,3,5,5,6; frame_done pulses once per 20 cycles.
REQ-032 SHALL cover: load 0,0,0,4,2 -> with the macro, an[4:2] stay high and only 2 and 4 are shown; without the macro, three zeros are shown; load 0,0,0,0,0 with the macro -> D1 shows 0.
REQ-033 SHALL cover: load D3=4'hA -> slot 2 shows seg=0111111.
REQ-034 SHALL cover: enable=0 mid-scan -> an=11111 next cycle; enable=1 resumes at the index the free-running scan has reached.
REQ-035 SHALL cover: load coincident with a tick, and rst asserted mid-scan -> the new digit is shown the next cycle; after rst the scan restarts at index 0 per REQ-023.
